// File: rtl/delivery_matrix_driver.sv
// Row-scanned driver for an 8x8 red/green LED matrix showing the delivery
// game's obstacle map, objective map and a blinking player pixel on row 7.
// Every frame works from a snapshot taken at frame start, so the picture
// never tears. A short blank at the start of each row suppresses ghosting.
module delivery_matrix_driver #(
  parameter int ROW_TICKS    = 1000,
  parameter int BLANK_TICKS  = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] map_obstacle,
  input  logic [63:0] map_objective,
  input  logic [3:0]  player_position,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_red,
  output logic [7:0]  col_green,
  output logic        frame_start,
  output logic [2:0]  db_row
);

  localparam int TW = (ROW_TICKS > 2) ? $clog2(ROW_TICKS) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(ROW_TICKS - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_TICKS);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    row_reg, row_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic          blink_reg, blink_next;
  logic          en_reg;
  logic [63:0]   snap_obs_reg, snap_obj_reg;
  logic [3:0]    snap_pos_reg;

  logic          visible;
  logic          player_row;
  logic [7:0]    obs_row, obj_row;

  // Scan counters: tick within row, row within frame, frame within blink half-period.
  always_comb begin
    tick_next  = tick_reg + TW'(1);
    row_next   = row_reg;
    frame_next = frame_reg;
    blink_next = blink_reg;
    if (tick_reg == T_LAST) begin
      tick_next = '0;
      row_next  = row_reg + 3'd1;
      if (row_reg == 3'd7) begin
        if (frame_reg == F_LAST) begin
          frame_next = '0;
          blink_next = ~blink_reg;
        end else begin
          frame_next = frame_reg + FW'(1);
        end
      end
    end
  end

  // State registers, the registered enable, and the frame-start snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_reg     <= '0;
      row_reg      <= '0;
      frame_reg    <= '0;
      blink_reg    <= 1'b1;
      en_reg       <= 1'b0;
      snap_obs_reg <= '0;
      snap_obj_reg <= '0;
      snap_pos_reg <= '0;
    end else begin
      tick_reg  <= tick_next;
      row_reg   <= row_next;
      frame_reg <= frame_next;
      blink_reg <= blink_next;
      en_reg    <= enable;
      if (frame_start) begin
        snap_obs_reg <= map_obstacle;
        snap_obj_reg <= map_objective;
        snap_pos_reg <= player_position;
      end
    end
  end

  assign frame_start = (row_reg == 3'd0) && (tick_reg == '0);
  assign db_row      = row_reg;
  assign visible     = en_reg && (tick_reg >= T_BLANK);
  assign player_row  = (row_reg == 3'd7) && !snap_pos_reg[3];
  assign obs_row     = snap_obs_reg[{row_reg, 3'b000} +: 8];
  assign obj_row     = snap_obj_reg[{row_reg, 3'b000} +: 8];
  assign row_sel     = visible ? (8'd1 << row_reg) : 8'd0;

  // Per-column colour: a lit player pixel shows yellow, then obstacle red, then objective green.
  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    logic player_lit;
    assign player_lit    = player_row && blink_reg && (snap_pos_reg[2:0] == 3'(gi));
    assign col_red[gi]   = visible && (player_lit || obs_row[gi]);
    assign col_green[gi] = visible && (player_lit || (!obs_row[gi] && obj_row[gi]));
  end

endmodule

// File: tb/tb_delivery_matrix_driver.sv
// Randomised and directed bench for delivery_matrix_driver, checked against
// a cycle-count based model of the scan, snapshot and blink rules.
module tb_delivery_matrix_driver;

  localparam int RT = 4;
  localparam int BT = 1;
  localparam int BF = 2;
  localparam int FRAME = 8 * RT;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] map_obstacle;
  logic [63:0] map_objective;
  logic [3:0]  player_position;
  logic [7:0]  row_sel, col_red, col_green;
  logic        frame_start;
  logic [2:0]  db_row;

  int vectors = 0;
  int miscompares = 0;

  // Model state: cycles since reset release, frame snapshot, previous enable.
  int          n;
  logic [63:0] m_obs, m_obj;
  logic [3:0]  m_pos;
  logic        en_prev;

  delivery_matrix_driver #(
    .ROW_TICKS(RT), .BLANK_TICKS(BT), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .map_obstacle(map_obstacle), .map_objective(map_objective),
    .player_position(player_position),
    .row_sel(row_sel), .col_red(col_red), .col_green(col_green),
    .frame_start(frame_start), .db_row(db_row)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic check_quiet(string tag);
    check({tag, ".row_sel"}, 32'(row_sel), 32'd0);
    check({tag, ".col_red"}, 32'(col_red), 32'd0);
    check({tag, ".col_green"}, 32'(col_green), 32'd0);
    check({tag, ".frame_start"}, 32'(frame_start), 32'd1);
    check({tag, ".db_row"}, 32'(db_row), 32'd0);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic cycle();
    int t, r, fr, i;
    bit vis, blink, pl;
    logic [7:0] e_row, e_red, e_grn;
    t     = n % RT;
    r     = (n / RT) % 8;
    fr    = n / FRAME;
    blink = ((fr / BF) % 2) == 0;
    vis   = (t >= BT) && en_prev;
    e_row = 8'd0; e_red = 8'd0; e_grn = 8'd0;
    if (vis) begin
      e_row = 8'd1 << r;
      for (int c = 0; c < 8; c++) begin
        i  = r * 8 + c;
        pl = (r == 7) && (m_pos < 8) && (c == int'(m_pos));
        if (pl && blink) begin
          e_red[c] = 1'b1; e_grn[c] = 1'b1;
        end else if (m_obs[i]) begin
          e_red[c] = 1'b1;
        end else if (m_obj[i]) begin
          e_grn[c] = 1'b1;
        end
      end
    end
    check("row_sel", 32'(row_sel), 32'(e_row));
    check("col_red", 32'(col_red), 32'(e_red));
    check("col_green", 32'(col_green), 32'(e_grn));
    check("frame_start", 32'(frame_start), 32'((n % FRAME) == 0));
    check("db_row", 32'(db_row), 32'(r));
    if ((n % FRAME) == 0) begin
      m_obs = map_obstacle;
      m_obj = map_objective;
      m_pos = player_position;
    end
    en_prev = enable;
    n++;
    @(posedge clock);
    #1;
  endtask

  task automatic run(int k);
    repeat (k) cycle();
  endtask

  task automatic model_reset();
    n = 0; en_prev = 1'b0;
    m_obs = '0; m_obj = '0; m_pos = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    map_obstacle = '0; map_objective = '0; player_position = 4'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_quiet("in_reset");
    reset = 1'b0;

    // Blank maps: pure scan sequence.
    run(FRAME);
    // Single obstacle at row 1 column 1.
    map_obstacle = 64'd1 << 9;
    run(2 * FRAME);
    // Obstacle beats objective at bit 20; objective-only at bit 21.
    map_obstacle  = 64'd1 << 20;
    map_objective = (64'd1 << 20) | (64'd1 << 21);
    run(2 * FRAME);
    // Blinking player at column 3 over six frames, then an off-grid position.
    map_obstacle = '0; map_objective = '0; player_position = 4'd3;
    run(6 * FRAME);
    player_position = 4'd9;
    run(2 * FRAME);
    // Mid-frame objective change is held off until the next frame.
    run(10);
    map_objective = '1;
    run(22 + FRAME);
    // Enable dropped for row 3 only.
    map_objective = '0; map_obstacle = 64'h00FF_0000_A5A5_0000;
    run(3 * RT);
    enable = 1'b0;
    run(RT);
    enable = 1'b1;
    run(FRAME - 4 * RT + FRAME);

    // Random maps, positions and enable activity.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(15) == 0) map_obstacle  = {$urandom, $urandom};
      if ($urandom_range(15) == 0) map_objective = {$urandom, $urandom};
      if ($urandom_range(7) == 0)  player_position = 4'($urandom_range(15));
      enable = ($urandom_range(7) != 0);
      cycle();
    end

    // Reset asserted during row 5.
    enable = 1'b1;
    while ((n % FRAME) != 5 * RT + 1) cycle();
    reset = 1'b1;
    #1;
    check_quiet("reset_row5");
    @(posedge clock);
    #1;
    check_quiet("reset_hold");
    model_reset();
    reset = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if ($urandom_range(7) == 0) map_obstacle  = {$urandom, $urandom};
      if ($urandom_range(7) == 0) map_objective = {$urandom, $urandom};
      if ($urandom_range(7) == 0) player_position = 4'($urandom_range(15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delivery_matrix_driver.md
Name: delivery_matrix_driver

Overview:
- Downstream display stage of the delivery game.
- Consumes the game's 64-bit obstacle map, 64-bit objective map and 4-bit player position, and scans them onto an 8x8 bicolour (red/green) LED matrix one row at a time.
- Latches a full-frame snapshot at each frame start so that map updates never tear mid-frame.
- Blinks the player pixel and blanks briefly between rows to suppress ghosting.

Parameters:
ROW_TICKS, 1000, clock cycles each row is held; must be >= 2.
BLANK_TICKS, 2, cycles at the start of each row with all outputs off; must be >= 1 and < ROW_TICKS.
BLINK_FRAMES, 16, frames per player blink half-period; must be >= 1.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = display on; 0 = outputs forced off, counters keep running.
map_obstacle  input  64  bit r*8+c = obstacle at row r, column c.
map_objective  input  64  same indexing as map_obstacle; objective cell.
player_position  input  4  player column on row 7; values 8..15 = player not drawn.
row_sel  output  8  one-hot, active-high row drive; bit r = row r.
col_red  output  8  active-high red column data; bit c = column c.
col_green  output  8  active-high green column data.
frame_start  output  1  one-cycle pulse at (row 0, tick 0).
db_row  output  3  current row index.

Behaviour:
- State registers: tick counter t (0..ROW_TICKS-1), row counter r (0..7), frame counter f (0..BLINK_FRAMES-1), blink_on, and snapshot registers snap_obs[63:0], snap_obj[63:0], snap_pos[3:0].
- Reset (asynchronous, takes effect immediately):
  - t=0, r=0, f=0, blink_on=1.
  - Snapshots = 0.
  - All outputs 0 except frame_start.
  - frame_start=1 while the state is (r=0, t=0), including the first cycle after reset release.
- Counting:
  - t increments every clock.
  - When t==ROW_TICKS-1: t wraps to 0 and r increments, wrapping 7 -> 0.
  - When r==7 and t==ROW_TICKS-1: f increments; if f==BLINK_FRAMES-1, f wraps to 0 and blink_on toggles.
- Snapshot:
  - On the clock edge ending the cycle with r==0 and t==0, snap_obs, snap_obj and snap_pos load from the inputs.
  - Input changes at any other time have no effect until the next frame.
- All outputs are decoded from registered state only; there is no combinational path from the map, position or enable inputs to the outputs.
- Blanking window (t < BLANK_TICKS) or enable==0: row_sel = col_red = col_green = 0.
- Visible window (t >= BLANK_TICKS and enable==1): row_sel = 1<<r. For each column c, with i = r*8+c:
  - Player pixel: r==7, snap_pos<8 and c==snap_pos[2:0].
    - blink_on=1: red=1 and green=1 (yellow).
    - blink_on=0: fall through to the map rules below.
  - snap_obs[i]=1: red=1, green=0. Obstacle has priority over objective.
  - Else snap_obj[i]=1: red=0, green=1.
  - Else: both 0.
- Timing figures:
  - frame_start = (r==0 && t==0), independent of enable.
  - db_row = r.
  - Frame period = 8*ROW_TICKS cycles.
  - Blink half-period = BLINK_FRAMES frames.
- Reset mid-frame: outputs drop to 0 immediately; the scan restarts at row 0 and a fresh snapshot is taken on the first cycle after release.
- enable toggling mid-row: takes effect on the next cycle without disturbing t, r, f or the snapshot.

Test Plan:
All scenarios use ROW_TICKS=4, BLANK_TICKS=1, BLINK_FRAMES=2, so a frame is 32 cycles.
1. Assert then release reset with all inputs 0 and enable=1:
   - While in reset, all outputs are 0.
   - First cycle after release: frame_start=1.
   - Cycles 1..3: row_sel=8'h01 with cols 0.
   - Cycle 5: row_sel=8'h02.
   - db_row sequences 0..7 then wraps.
2. map_obstacle bit 9 set before frame start:
   - Row 1 visible cycles show row_sel=8'h02, col_red=8'h02, col_green=0.
   - All other rows show cols 0.
3. map_obstacle and map_objective both set at bit 20:
   - Row 2 shows col_red=8'h10, col_green=0 (obstacle priority).
   - Objective-only bit 21 shows col_green=8'h20 on row 2.
4. player_position=3, maps 0:
   - Row 7 shows col_red=col_green=8'h08 in frames 0-1, nothing in frames 2-3, and lit again in frames 4-5.
   - player_position=9 draws nothing in any frame.
5. Change map_objective from 0 to all-ones at cycle 10 (mid-frame):
   - Rows 2..7 of the current frame stay dark.
   - From the next frame (cycle 32 onward), every visible row shows col_green=8'hFF.
6. Abnormal control inputs:
   - enable=0 during row 3: outputs are 0 and db_row still advances; re-enable returns to the correct row.
   - Reset asserted at row 5: outputs are 0 immediately; after release the scan restarts at row 0 with frame_start=1.
